// File: rtl/beat_feature_extractor.sv
// Reads one full beat from the sample buffer and reduces it to peak, min and sum.
// The features are then presented to the host through a valid/ack handshake.
//   state | meaning
//   IDLE  | waiting for buf_full
//   READ  | buf_read held high for BEAT_LEN contiguous cycles
//   DRAIN | last registered sample arrives and is captured
//   CLEAR | buf_clear pulse, features copied to output registers
//   DONE  | feat_valid high until feat_ack
module beat_feature_extractor #(
  parameter int BEAT_LEN = 100,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 7,
  parameter int SUM_W    = 23
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              buf_full,
  input  logic [DATA_W-1:0] buf_dataout,
  output logic              buf_read,
  output logic              buf_clear,
  output logic              feat_valid,
  input  logic              feat_ack,
  output logic [DATA_W-1:0] peak_val,
  output logic [IDX_W-1:0]  peak_idx,
  output logic [DATA_W-1:0] min_val,
  output logic [IDX_W-1:0]  min_idx,
  output logic [SUM_W-1:0]  sample_sum,
  output logic [15:0]       beat_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] CLEAR = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEAT_LEN - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              cap_en_q;
  logic [IDX_W-1:0]  cap_idx_q;
  logic              clr_acc;

  logic [DATA_W-1:0] pk_val_q, pk_val_d;
  logic [IDX_W-1:0]  pk_idx_q, pk_idx_d;
  logic [DATA_W-1:0] mn_val_q, mn_val_d;
  logic [IDX_W-1:0]  mn_idx_q, mn_idx_d;
  logic [SUM_W-1:0]  sum_q, sum_d;

  logic [DATA_W-1:0] peak_val_q, min_val_q;
  logic [IDX_W-1:0]  peak_idx_q, min_idx_q;
  logic [SUM_W-1:0]  sample_sum_q;
  logic [15:0]       beat_count_q;

  logic [SUM_W-1:0]  sample_ext;

  assign sample_ext = {{(SUM_W-DATA_W){1'b0}}, buf_dataout};

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    clr_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_full) begin
          state_d  = READ;
          rd_cnt_d = '0;
          clr_acc  = 1'b1;
        end
      end
      READ: begin
        if (rd_cnt_q == LAST_IDX) state_d = DRAIN;
        else                      rd_cnt_d = rd_cnt_q + IDX_W'(1);
      end
      DRAIN:   state_d = CLEAR;
      CLEAR:   state_d = DONE;
      DONE:    if (feat_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample 0 seeds the extrema; strict compares keep the earliest index on ties.
  always_comb begin
    pk_val_d = pk_val_q;
    pk_idx_d = pk_idx_q;
    mn_val_d = mn_val_q;
    mn_idx_d = mn_idx_q;
    sum_d    = sum_q;
    if (clr_acc) begin
      pk_val_d = '0;
      pk_idx_d = '0;
      mn_val_d = '0;
      mn_idx_d = '0;
      sum_d    = '0;
    end else if (cap_en_q) begin
      if (cap_idx_q == '0) begin
        pk_val_d = buf_dataout;
        pk_idx_d = '0;
        mn_val_d = buf_dataout;
        mn_idx_d = '0;
        sum_d    = sample_ext;
      end else begin
        if (buf_dataout > pk_val_q) begin
          pk_val_d = buf_dataout;
          pk_idx_d = cap_idx_q;
        end
        if (buf_dataout < mn_val_q) begin
          mn_val_d = buf_dataout;
          mn_idx_d = cap_idx_q;
        end
        sum_d = sum_q + sample_ext;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      cap_en_q     <= 1'b0;
      cap_idx_q    <= '0;
      pk_val_q     <= '0;
      pk_idx_q     <= '0;
      mn_val_q     <= '0;
      mn_idx_q     <= '0;
      sum_q        <= '0;
      peak_val_q   <= '0;
      peak_idx_q   <= '0;
      min_val_q    <= '0;
      min_idx_q    <= '0;
      sample_sum_q <= '0;
      beat_count_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      cap_en_q  <= (state_q == READ);
      cap_idx_q <= rd_cnt_q;
      pk_val_q  <= pk_val_d;
      pk_idx_q  <= pk_idx_d;
      mn_val_q  <= mn_val_d;
      mn_idx_q  <= mn_idx_d;
      sum_q     <= sum_d;
      if (state_q == CLEAR) begin
        peak_val_q   <= pk_val_q;
        peak_idx_q   <= pk_idx_q;
        min_val_q    <= mn_val_q;
        min_idx_q    <= mn_idx_q;
        sample_sum_q <= sum_q;
      end
      if ((state_q == DONE) && feat_ack && (beat_count_q != 16'hFFFF))
        beat_count_q <= beat_count_q + 16'd1;
    end
  end

  assign buf_read   = (state_q == READ);
  assign buf_clear  = (state_q == CLEAR);
  assign feat_valid = (state_q == DONE);
  assign peak_val   = peak_val_q;
  assign peak_idx   = peak_idx_q;
  assign min_val    = min_val_q;
  assign min_idx    = min_idx_q;
  assign sample_sum = sample_sum_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_beat_feature_extractor.sv
// Directed bench for beat_feature_extractor: a registered-buffer model feeds beats,
// expected features go into a queue and a monitor checks each accepted result.
module tb_beat_feature_extractor;

  logic        clock = 1'b0;
  logic        reset, buf_full, feat_ack;
  logic [15:0] buf_dataout;
  logic        buf_read, buf_clear, feat_valid;
  logic [15:0] peak_val, min_val, beat_count;
  logic [6:0]  peak_idx, min_idx;
  logic [22:0] sample_sum;

  beat_feature_extractor dut (
    .clock(clock), .reset(reset), .buf_full(buf_full), .buf_dataout(buf_dataout),
    .buf_read(buf_read), .buf_clear(buf_clear), .feat_valid(feat_valid), .feat_ack(feat_ack),
    .peak_val(peak_val), .peak_idx(peak_idx), .min_val(min_val), .min_idx(min_idx),
    .sample_sum(sample_sum), .beat_count(beat_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] pv;
    logic [6:0]  pi;
    logic [15:0] mv;
    logic [6:0]  mi;
    logic [22:0] sum;
  } feat_t;

  feat_t expq[$];
  int checks = 0;
  int failures = 0;
  int exp_beats = 0;

  // buffer model: registered read data, pointer rewinds whenever buf_read is low
  logic [15:0] mem [0:99];
  int rptr = 0;
  always @(posedge clock) begin
    if (buf_read) begin
      buf_dataout <= mem[rptr % 100];
      rptr <= rptr + 1;
    end else begin
      rptr <= 0;
    end
  end

  int run_len = 0, last_run = 0, clr_cnt = 0;
  always @(posedge clock) begin
    if (buf_read) run_len <= run_len + 1;
    else begin
      if (run_len != 0) last_run <= run_len;
      run_len <= 0;
    end
    if (buf_clear) clr_cnt <= clr_cnt + 1;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clock) begin
    if (!reset && feat_valid && feat_ack) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got peak_val 0x%0h with no expected beat queued", peak_val);
      end else begin
        feat_t e;
        e = expq.pop_front();
        chk("peak_val", 32'(peak_val), 32'(e.pv));
        chk("peak_idx", 32'(peak_idx), 32'(e.pi));
        chk("min_val", 32'(min_val), 32'(e.mv));
        chk("min_idx", 32'(min_idx), 32'(e.mi));
        chk("sample_sum", 32'(sample_sum), 32'(e.sum));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input int pat);
    for (int k = 0; k < 100; k++) begin
      case (pat)
        0: mem[k] = 16'(k);
        1: mem[k] = 16'd500;
        2: mem[k] = 16'hFFFF;
        3: mem[k] = (k == 37) ? 16'h0001 : 16'h8000;
        4: mem[k] = 16'(100 - k);
        default: mem[k] = (k == 20 || k == 60) ? 16'd200 : (k == 30 || k == 80) ? 16'd2 : 16'd7;
      endcase
    end
  endtask

  task automatic push(input int pat);
    feat_t e;
    case (pat)
      0: e = '{16'd99, 7'd99, 16'd0, 7'd0, 23'd4950};
      1: e = '{16'd500, 7'd0, 16'd500, 7'd0, 23'd50000};
      2: e = '{16'hFFFF, 7'd0, 16'hFFFF, 7'd0, 23'd6553500};
      3: e = '{16'h8000, 7'd0, 16'h0001, 7'd37, 23'd3244033};
      4: e = '{16'd100, 7'd0, 16'd1, 7'd99, 23'd5050};
      default: e = '{16'd200, 7'd20, 16'd2, 7'd30, 23'd1076};
    endcase
    expq.push_back(e);
  endtask

  task automatic wait_clear();
    int n = 0;
    while (!buf_clear && n < 400) begin
      tick(1);
      n++;
    end
    chk("clear_seen", 32'(buf_clear), 32'd1);
  endtask

  task automatic finish_beat();
    wait_clear();
    buf_full = 1'b0;
    tick(1);
    chk("valid_after_clear", 32'(feat_valid), 32'd1);
    feat_ack = 1'b1;
    tick(1);
    feat_ack = 1'b0;
    exp_beats++;
    chk("beat_count", 32'(beat_count), 32'(exp_beats));
  endtask

  task automatic run_beat(input int pat);
    load(pat);
    push(pat);
    buf_full = 1'b1;
    finish_beat();
  endtask

  initial begin
    reset = 1'b1;
    buf_full = 1'b0;
    feat_ack = 1'b0;
    for (int k = 0; k < 100; k++) mem[k] = 16'd0;
    tick(3);
    @(negedge clock);
    chk("rst_buf_read", 32'(buf_read), 32'd0);
    chk("rst_buf_clear", 32'(buf_clear), 32'd0);
    chk("rst_feat_valid", 32'(feat_valid), 32'd0);
    chk("rst_peak_val", 32'(peak_val), 32'd0);
    chk("rst_sample_sum", 32'(sample_sum), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // ramp beat with cycle-exact timing: buf_full seen at edge ending cycle t
    load(0);
    push(0);
    buf_full = 1'b1;
    for (int k = 1; k <= 104; k++) begin
      tick(1);
      if (k == 1) buf_full = 1'b0;
      if (k == 103) feat_ack = 1'b1;
      if (k == 104) feat_ack = 1'b0;
      @(negedge clock);
      chk($sformatf("ramp_buf_read_t%0d", k), 32'(buf_read), 32'(k >= 1 && k <= 100));
      chk($sformatf("ramp_buf_clear_t%0d", k), 32'(buf_clear), 32'(k == 102));
      chk($sformatf("ramp_feat_valid_t%0d", k), 32'(feat_valid), 32'(k == 103));
    end
    exp_beats++;
    chk("ramp_beat_count", 32'(beat_count), 32'(exp_beats));
    chk("ramp_read_len", 32'(last_run), 32'd100);
    tick(2);

    run_beat(1);
    run_beat(2);
    run_beat(3);
    tick(2);

    // backpressure: ack withheld 20 cycles while the buffer is full again
    load(1);
    push(1);
    buf_full = 1'b1;
    wait_clear();
    load(3);
    tick(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("bp_valid", 32'(feat_valid), 32'd1);
      chk("bp_no_read", 32'(buf_read), 32'd0);
      chk("bp_peak_hold", 32'(peak_val), 32'd500);
      chk("bp_sum_hold", 32'(sample_sum), 32'd50000);
      tick(1);
    end
    push(3);
    feat_ack = 1'b1;
    @(negedge clock);
    chk("bp_no_read_ack", 32'(buf_read), 32'd0);
    tick(1);
    feat_ack = 1'b0;
    exp_beats++;
    chk("bp_beat_count", 32'(beat_count), 32'(exp_beats));
    chk("bp_idle_after_ack", 32'(buf_read), 32'd0);
    chk("bp_valid_drop", 32'(feat_valid), 32'd0);
    tick(1);
    chk("bp_read_starts", 32'(buf_read), 32'd1);
    finish_beat();
    chk("bp_read_len", 32'(last_run), 32'd100);
    tick(2);

    // reset in the middle of a read
    begin
      int n = 0;
      int clr0;
      load(0);
      buf_full = 1'b1;
      while (!buf_read && n < 10) begin
        tick(1);
        n++;
      end
      chk("rs_read_start", 32'(buf_read), 32'd1);
      tick(50);
      buf_full = 1'b0;
      reset = 1'b1;
      clr0 = clr_cnt;
      tick(1);
      chk("rs_buf_read", 32'(buf_read), 32'd0);
      chk("rs_feat_valid", 32'(feat_valid), 32'd0);
      chk("rs_beat_count", 32'(beat_count), 32'd0);
      chk("rs_peak_val", 32'(peak_val), 32'd0);
      reset = 1'b0;
      exp_beats = 0;
      tick(5);
      chk("rs_no_clear", 32'(clr_cnt), 32'(clr0));
      chk("rs_partial_len", 32'(last_run), 32'd51);
    end
    run_beat(5);
    chk("rs_full_len", 32'(last_run), 32'd100);
    tick(2);

    // three back-to-back beats with ack tied high
    feat_ack = 1'b1;
    load(0);
    push(0);
    buf_full = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_clear();
      if (b == 0) begin
        load(4);
        push(4);
      end else if (b == 1) begin
        load(5);
        push(5);
      end else begin
        buf_full = 1'b0;
      end
      tick(1);
    end
    tick(3);
    feat_ack = 1'b0;
    exp_beats += 3;
    chk("b2b_beat_count", 32'(beat_count), 32'(exp_beats));
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
